regfile_write_arbiter: RTL and testbench

- Shares the register file's single write port among NREQ requesters: port 0 is pipeline writeback, port 1 is multdiv completion, port 2 is the IO sampler.
- Grants at most one write per cycle and drives the register file write controls from registered outputs.
- Port 0 has priority. Ports 1..NREQ-1 rotate round-robin, with an anti-starvation override.
- Writes to r0 are accepted and dropped.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_write_arbiter_rr_picker.sv | 36 +++
 rtl/regfile_write_arbiter.sv | 129 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// ============================================================================
// Module : regfile_pkg
// Shared constants for the register file write port and its arbiters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;
    localparam int DEF_AW       = 5;
    localparam int DEF_DW       = 32;
    localparam int DEF_MAX_WAIT = 4;
    localparam int REG_ZERO     = 0;
    localparam int PORT_WB      = 0;
    localparam int PORT_MD      = 1;
    localparam int PORT_IO      = 2;
endpackage

`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_picker.sv
// ============================================================================
// Module : rr_picker
// Combinational rotating first-one finder: search starts at ptr, wraps at N.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_picker
    import regfile_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    always_comb begin : p_pick
        int  j;
        logic found;
        grant = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                grant[j] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
// ============================================================================
// Module : regfile_write_arbiter
// Single register file write port shared by NREQ requesters; registered output.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]  req_ready,
    output logic             ctrl_writeEnable,
    output logic [AW-1:0]    ctrl_writeReg,
    output logic [DW-1:0]    data_writeReg,
    output logic             wb_stall,
    output logic [2:0]       grant_id
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0]   r_wait [1:NREQ-1];
    logic [2:0]      r_rr_ptr;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_data;
    logic [2:0]      r_gid;

    logic [NREQ-1:0] w_grant;
    logic [NREQ-2:0] w_rr_grant;
    logic            w_ovr;
    logic            w_stall;
    logic [2:0]      w_gid;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_data;

    // Picker bit 0 corresponds to port 1, so the pointer is shifted down by one.
    rr_picker #(
        .N  (NREQ - 1),
        .PW (3)
    ) u_rr_picker (
        .req   (req_valid[NREQ-1:1]),
        .ptr   (r_rr_ptr - 3'd1),
        .grant (w_rr_grant)
    );

    always_comb begin
        w_grant = '0;
        w_ovr   = 1'b0;
        w_stall = 1'b0;
        for (int i = 1; i < NREQ; i++) begin
            if (!w_ovr && req_valid[i] && (r_wait[i] == CW'(MAX_WAIT))) begin
                w_grant[i] = 1'b1;
                w_ovr      = 1'b1;
            end
        end
        if (w_ovr) begin
            w_stall = req_valid[PORT_WB];
        end else if (req_valid[PORT_WB]) begin
            w_grant[PORT_WB] = 1'b1;
        end else begin
            w_grant[NREQ-1:1] = w_rr_grant;
        end
    end

    always_comb begin
        w_gid  = '0;
        w_addr = '0;
        w_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_gid  = 3'(i);
                w_addr = req_addr[i*AW +: AW];
                w_data = req_data[i*DW +: DW];
            end
        end
    end

    // Flops use the ungated grant: reset already holds them, keeping the reset net async-only.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_gid    <= '0;
            r_rr_ptr <= 3'd1;
            for (int i = 1; i < NREQ; i++) begin
                r_wait[i] <= '0;
            end
        end else begin
            r_we <= 1'b0;
            if (|w_grant) begin
                r_we   <= (w_addr != AW'(REG_ZERO));
                r_addr <= w_addr;
                r_data <= w_data;
                r_gid  <= w_gid;
                if (w_gid != 3'(PORT_WB)) begin
                    r_rr_ptr <= (w_gid == 3'(NREQ - 1)) ? 3'd1 : w_gid + 3'd1;
                end
            end
            for (int i = 1; i < NREQ; i++) begin
                if (!req_valid[i] || w_grant[i]) begin
                    r_wait[i] <= '0;
                end else if (r_wait[i] != CW'(MAX_WAIT)) begin
                    r_wait[i] <= r_wait[i] + 1'b1;
                end
            end
        end
    end

    assign req_ready        = ctrl_reset ? w_grant : '0;
    assign wb_stall         = ctrl_reset & w_stall;
    assign ctrl_writeEnable = r_we;
    assign ctrl_writeReg    = r_addr;
    assign data_writeReg    = r_data;
    assign grant_id         = r_gid;

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// ============================================================================
// Module : tb_regfile_write_arbiter
// Directed self-checking bench for regfile_write_arbiter (NREQ=3, MAX_WAIT=4).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic               clock;
    logic               ctrl_reset;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               ctrl_writeEnable;
    logic [AW-1:0]      ctrl_writeReg;
    logic [DW-1:0]      data_writeReg;
    logic               wb_stall;
    logic [2:0]         grant_id;

    int vectors;
    int miscompares;

    regfile_write_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .MAX_WAIT(4)
    ) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .req_valid        (req_valid),
        .req_addr         (req_addr),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .wb_stall         (wb_stall),
        .grant_id         (grant_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // A request must stay valid until accepted.
    logic [NREQ-1:0] pend;
    always @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            pend <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                assert (!(pend[i] && !req_valid[i])) else $error("protocol: port %0d dropped valid before accept", i);
            pend <= req_valid & ~req_ready;
        end
    end

    task automatic set_port(input int p, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[p]         = v;
        req_addr[p*AW +: AW] = a;
        req_data[p*DW +: DW] = d;
    endtask

    // Called at a negedge: drop each request once accepted.
    task automatic drain;
        logic [NREQ-1:0] keep;
        int c;
        c = 0;
        while (req_valid != '0 && c < 10) begin
            keep = req_valid & ~req_ready;
            @(posedge clock); #1;
            req_valid = keep;
            @(negedge clock);
            c++;
        end
        vectors++;
        if (req_valid !== '0) begin
            miscompares++;
            $display("FAIL drain_timeout: valid=%b required=000", req_valid);
        end
    endtask

    task automatic test_reset;
        ctrl_reset = 1'b1;
        req_valid  = '0;
        req_addr   = '0;
        req_data   = '0;
        #2 ctrl_reset = 1'b0;
        set_port(PORT_WB, 1'b1, 5'd1, 32'h1);
        @(negedge clock);
        vectors++; if (req_ready !== 3'b000) begin miscompares++; $display("FAIL ready_in_reset: got %b required 000", req_ready); end
        vectors++; if (ctrl_writeEnable !== 1'b0) begin miscompares++; $display("FAIL we_in_reset: got %b required 0", ctrl_writeEnable); end
        req_valid = '0;
        @(posedge clock); #1 ctrl_reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            vectors++; if (ctrl_writeEnable !== 1'b0) begin miscompares++; $display("FAIL idle_we c%0d: got %b required 0", k, ctrl_writeEnable); end
            vectors++; if (req_ready !== 3'b000) begin miscompares++; $display("FAIL idle_ready c%0d: got %b required 000", k, req_ready); end
            vectors++; if (grant_id !== 3'd0) begin miscompares++; $display("FAIL idle_gid c%0d: got %0d required 0", k, grant_id); end
            vectors++; if (ctrl_writeReg !== 5'd0 || data_writeReg !== 32'd0) begin miscompares++; $display("FAIL idle_regs c%0d: got %0d/%h required 0/0", k, ctrl_writeReg, data_writeReg); end
            vectors++; if (wb_stall !== 1'b0) begin miscompares++; $display("FAIL idle_stall c%0d: got %b required 0", k, wb_stall); end
        end
    endtask

    task automatic test_port0_alone;
        @(posedge clock); #1 set_port(PORT_WB, 1'b1, 5'd5, 32'hDEADBEEF);
        @(negedge clock);
        vectors++; if (req_ready !== 3'b001) begin miscompares++; $display("FAIL p0_ready: got %b required 001", req_ready); end
        vectors++; if (ctrl_writeEnable !== 1'b0) begin miscompares++; $display("FAIL p0_we_early: got %b required 0", ctrl_writeEnable); end
        @(posedge clock); #1 req_valid = '0;
        @(negedge clock);
        vectors++; if (ctrl_writeEnable !== 1'b1) begin miscompares++; $display("FAIL p0_we: got %b required 1", ctrl_writeEnable); end
        vectors++; if (ctrl_writeReg !== 5'd5) begin miscompares++; $display("FAIL p0_addr: got %0d required 5", ctrl_writeReg); end
        vectors++; if (data_writeReg !== 32'hDEADBEEF) begin miscompares++; $display("FAIL p0_data: got %h required deadbeef", data_writeReg); end
        vectors++; if (grant_id !== 3'd0) begin miscompares++; $display("FAIL p0_gid: got %0d required 0", grant_id); end
        @(negedge clock);
        vectors++; if (ctrl_writeEnable !== 1'b0) begin miscompares++; $display("FAIL p0_we_pulse: got %b required 0", ctrl_writeEnable); end
        vectors++; if (ctrl_writeReg !== 5'd5 || data_writeReg !== 32'hDEADBEEF) begin miscompares++; $display("FAIL p0_hold: got %0d/%h required 5/deadbeef", ctrl_writeReg, data_writeReg); end
    endtask

    task automatic test_round_robin;
        logic [2:0] exp_rdy;
        logic [2:0] exp_gid;
        @(posedge clock); #1;
        set_port(PORT_MD, 1'b1, 5'd7, 32'h11110000);
        set_port(PORT_IO, 1'b1, 5'd9, 32'h22220000);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            exp_rdy = (k % 2 == 0) ? 3'b010 : 3'b100;
            vectors++; if (req_ready !== exp_rdy) begin miscompares++; $display("FAIL rr_ready c%0d: got %b required %b", k, req_ready, exp_rdy); end
            if (k > 0) begin
                exp_gid = (k % 2 == 1) ? 3'd1 : 3'd2;
                vectors++; if (ctrl_writeEnable !== 1'b1 || grant_id !== exp_gid) begin miscompares++; $display("FAIL rr_out c%0d: got we=%b gid=%0d required we=1 gid=%0d", k, ctrl_writeEnable, grant_id, exp_gid); end
                vectors++; if (ctrl_writeReg !== ((exp_gid == 3'd1) ? 5'd7 : 5'd9)) begin miscompares++; $display("FAIL rr_addr c%0d: got %0d required %0d", k, ctrl_writeReg, (exp_gid == 3'd1) ? 7 : 9); end
            end
            if (k < 3) @(posedge clock);
        end
        drain();
    endtask

    task automatic test_starvation;
        logic [2:0] exp_rdy;
        logic       exp_stall;
        logic [2:0] exp_gid;
        @(posedge clock); #1;
        set_port(PORT_WB, 1'b1, 5'd3, 32'h000000A0);
        set_port(PORT_MD, 1'b1, 5'd4, 32'h000000B0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            exp_stall = (k == 4 || k == 9);
            exp_rdy   = exp_stall ? 3'b010 : 3'b001;
            vectors++; if (req_ready !== exp_rdy) begin miscompares++; $display("FAIL starve_ready c%0d: got %b required %b", k, req_ready, exp_rdy); end
            vectors++; if (wb_stall !== exp_stall) begin miscompares++; $display("FAIL starve_stall c%0d: got %b required %b", k, wb_stall, exp_stall); end
            if (k > 0) begin
                exp_gid = (k == 5) ? 3'd1 : 3'd0;
                vectors++; if (ctrl_writeEnable !== 1'b1 || grant_id !== exp_gid) begin miscompares++; $display("FAIL starve_out c%0d: got we=%b gid=%0d required we=1 gid=%0d", k, ctrl_writeEnable, grant_id, exp_gid); end
            end
            if (k < 9) @(posedge clock);
        end
        drain();
    endtask

    task automatic test_r0_write;
        @(posedge clock); #1 set_port(PORT_IO, 1'b1, 5'd0, 32'h00001234);
        @(negedge clock);
        vectors++; if (req_ready !== 3'b100) begin miscompares++; $display("FAIL r0_ready: got %b required 100", req_ready); end
        @(posedge clock); #1 req_valid = '0;
        @(negedge clock);
        vectors++; if (ctrl_writeEnable !== 1'b0) begin miscompares++; $display("FAIL r0_we: got %b required 0", ctrl_writeEnable); end
        vectors++; if (grant_id !== 3'd2) begin miscompares++; $display("FAIL r0_gid: got %0d required 2", grant_id); end
        vectors++; if (data_writeReg !== 32'h00001234) begin miscompares++; $display("FAIL r0_data: got %h required 00001234", data_writeReg); end
    endtask

    task automatic test_reset_midflight;
        @(posedge clock); #1 set_port(PORT_MD, 1'b1, 5'd6, 32'h00000066);
        @(negedge clock);
        vectors++; if (req_ready !== 3'b010) begin miscompares++; $display("FAIL mid_ready: got %b required 010", req_ready); end
        @(posedge clock); #1 req_valid = '0;
        @(negedge clock);
        vectors++; if (ctrl_writeEnable !== 1'b1 || grant_id !== 3'd1) begin miscompares++; $display("FAIL mid_capture: got we=%b gid=%0d required we=1 gid=1", ctrl_writeEnable, grant_id); end
        #1 ctrl_reset = 1'b0;
        #1;
        vectors++; if (ctrl_writeEnable !== 1'b0) begin miscompares++; $display("FAIL mid_async_we: got %b required 0", ctrl_writeEnable); end
        vectors++; if (grant_id !== 3'd0 || ctrl_writeReg !== 5'd0 || data_writeReg !== 32'd0) begin miscompares++; $display("FAIL mid_async_regs: got gid=%0d addr=%0d data=%h required 0/0/0", grant_id, ctrl_writeReg, data_writeReg); end
        @(posedge clock); #1 ctrl_reset = 1'b1;
        set_port(PORT_MD, 1'b1, 5'd10, 32'hAAAA0001);
        set_port(PORT_IO, 1'b1, 5'd11, 32'hBBBB0002);
        @(negedge clock);
        vectors++; if (req_ready !== 3'b010) begin miscompares++; $display("FAIL mid_rrptr: got %b required 010", req_ready); end
        drain();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_port0_alone();
        test_round_robin();
        test_starvation();
        test_r0_write();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
